// File: rtl/ofs_plat_ccip_wr_burst_splitter.sv
// ofs_plat_ccip_wr_burst_splitter: split Avalon host write bursts into naturally aligned CCI-P c1 packets
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_*                    Avalon-style write beat stream (address/burstcount/rob sampled on first beat)
//   tx_almfull              FIU c1 almost-full, registered into in_ready
//   tx_*                    registered CCI-P c1 write requests (WRLINE / WRFENCE / INTR)
//   rsp_in_*                FIU c1 responses
//   rsp_valid, rsp_rob_idx  responses mapped back to ROB indices, 1-cycle latency
//   burst_err               sticky flag for illegal burstcount / fence / interrupt usage
//   stat_pkts, stat_lines   saturating issue counters, present only with OFS_PLAT_CCIP_WR_SPLIT_STATS_EN
module ofs_plat_ccip_wr_burst_splitter #(
   parameter int ADDR_WIDTH = 42,
   parameter int DATA_WIDTH = 512,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int ROB_IDX_WIDTH = 9,
   parameter int N_INTR_VECTORS = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_WIDTH-1:0]      in_address,
   input  logic [BURST_CNT_WIDTH-1:0] in_burstcount,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [ROB_IDX_WIDTH-1:0]   in_rob_idx,
   input  logic                       in_fence,
   input  logic                       in_intr,
   input  logic                       tx_almfull,
   output logic                       tx_valid,
   output logic                       tx_sop,
   output logic [1:0]                 tx_cl_len,
   output logic [1:0]                 tx_req_type,
   output logic [ADDR_WIDTH-1:0]      tx_address,
   output logic [15:0]                tx_mdata,
   output logic [DATA_WIDTH-1:0]      tx_data,
   input  logic                       rsp_in_valid,
   input  logic [1:0]                 rsp_in_type,
   input  logic [15:0]                rsp_in_mdata,
   output logic                       rsp_valid,
   output logic [ROB_IDX_WIDTH-1:0]   rsp_rob_idx,
`ifdef OFS_PLAT_CCIP_WR_SPLIT_STATS_EN
   output logic [31:0]                stat_pkts,
   output logic [31:0]                stat_lines,
`endif
   output logic                       burst_err
);
   localparam int VW = (N_INTR_VECTORS > 1) ? $clog2(N_INTR_VECTORS) : 1;
   typedef enum logic {BURST_START, IN_BURST} state_t;
   state_t state;
   logic [BURST_CNT_WIDTH-1:0] rem;
   logic [1:0] pkt_left;
   logic [ADDR_WIDTH-1:0] pkt_base, cur_addr;
   logic [ROB_IDX_WIDTH-1:0] cur_rob;
   logic [ROB_IDX_WIDTH-1:0] intr_rob [N_INTR_VECTORS];
   logic accept, start, new_pkt, special, bad_cmd;
   logic [BURST_CNT_WIDTH-1:0] src_r;
   logic [ADDR_WIDTH-1:0] src_a;
   logic [ROB_IDX_WIDTH-1:0] src_rob;
   logic [2:0] len;
   logic [1:0] line;
   logic [VW-1:0] vec;
   logic unused_mdata;
   assign unused_mdata = ^rsp_in_mdata;
   // A new packet takes its source either from the first beat or from the saved burst position.
   always_comb begin
      accept = in_valid && in_ready;
      start = state == BURST_START;
      new_pkt = start || pkt_left == 2'd0;
      src_r = !start ? rem : (in_burstcount == '0 ? BURST_CNT_WIDTH'(1) : in_burstcount);
      src_a = start ? in_address : cur_addr;
      src_rob = start ? in_rob_idx : cur_rob;
      len = (src_r > BURST_CNT_WIDTH'(3) && src_a[1:0] == 2'b00) ? 3'd4 :
            (src_r > BURST_CNT_WIDTH'(1) && !src_a[0]) ? 3'd2 : 3'd1;
      special = start && in_burstcount == BURST_CNT_WIDTH'(1) && (in_fence || in_intr);
      bad_cmd = ((in_fence || in_intr) && !special) || (start && in_burstcount == '0);
      line = tx_cl_len + 2'd1 - pkt_left;
      vec = in_address[VW-1:0];
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= BURST_START;
         rem <= '0;
         pkt_left <= '0;
         pkt_base <= '0;
         cur_addr <= '0;
         cur_rob <= '0;
         in_ready <= 1'b0;
         tx_valid <= 1'b0;
         tx_sop <= 1'b0;
         tx_cl_len <= '0;
         tx_req_type <= '0;
         tx_address <= '0;
         tx_mdata <= '0;
         tx_data <= '0;
         rsp_valid <= 1'b0;
         rsp_rob_idx <= '0;
         burst_err <= 1'b0;
      end else begin
         in_ready <= !tx_almfull;
         tx_valid <= accept;
         rsp_valid <= rsp_in_valid;
         rsp_rob_idx <= rsp_in_type == 2'd2 ? intr_rob[rsp_in_mdata[VW-1:0]] : rsp_in_mdata[ROB_IDX_WIDTH-1:0];
         if (accept) begin
            burst_err <= burst_err || bad_cmd;
            tx_data <= in_data;
            if (new_pkt) begin
               tx_sop <= 1'b1;
               tx_cl_len <= 2'(len - 3'd1);
               tx_req_type <= special ? (in_intr ? 2'd2 : 2'd1) : 2'd0;
               tx_address <= src_a;
               tx_mdata <= (special && in_intr) ? 16'(vec) : 16'(src_rob);
               rem <= src_r - BURST_CNT_WIDTH'(len);
               cur_addr <= src_a + ADDR_WIDTH'(len);
               cur_rob <= src_rob + ROB_IDX_WIDTH'(len);
               pkt_base <= src_a;
               pkt_left <= 2'(len - 3'd1);
               state <= src_r == BURST_CNT_WIDTH'(1) ? BURST_START : IN_BURST;
            end else begin
               tx_sop <= 1'b0;
               tx_req_type <= 2'd0;
               tx_address <= {pkt_base[ADDR_WIDTH-1:2], pkt_base[1:0] | line};
               pkt_left <= pkt_left - 2'd1;
               state <= (rem == '0 && pkt_left == 2'd1) ? BURST_START : IN_BURST;
            end
         end
      end
   end
   // Interrupt table is deliberately unreset; reads above see the pre-write value.
   always_ff @(posedge clk) begin
      if (accept && special && in_intr)
         intr_rob[vec] <= in_rob_idx;
   end
`ifdef OFS_PLAT_CCIP_WR_SPLIT_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_pkts <= '0;
         stat_lines <= '0;
      end else if (tx_valid) begin
         stat_lines <= stat_lines == '1 ? stat_lines : stat_lines + 32'd1;
         stat_pkts <= (tx_sop && stat_pkts != '1) ? stat_pkts + 32'd1 : stat_pkts;
      end
   end
`endif
endmodule

// File: tb/tb_ofs_plat_ccip_wr_burst_splitter.sv
// tb_ofs_plat_ccip_wr_burst_splitter: directed self-checking bench for the CCI-P write burst splitter
module tb_ofs_plat_ccip_wr_burst_splitter;
   logic clk, reset_n;
   logic in_valid, in_ready, in_fence, in_intr, tx_almfull;
   logic [41:0] in_address, tx_address;
   logic [6:0] in_burstcount;
   logic [511:0] in_data, tx_data;
   logic [8:0] in_rob_idx, rsp_rob_idx;
   logic tx_valid, tx_sop, rsp_in_valid, rsp_valid, burst_err;
   logic [1:0] tx_cl_len, tx_req_type, rsp_in_type;
   logic [15:0] tx_mdata, rsp_in_mdata;
   int tests = 0;
   int fails = 0;

   ofs_plat_ccip_wr_burst_splitter dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_address(in_address),
      .in_burstcount(in_burstcount), .in_data(in_data), .in_rob_idx(in_rob_idx),
      .in_fence(in_fence), .in_intr(in_intr), .tx_almfull(tx_almfull),
      .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_cl_len(tx_cl_len), .tx_req_type(tx_req_type),
      .tx_address(tx_address), .tx_mdata(tx_mdata), .tx_data(tx_data),
      .rsp_in_valid(rsp_in_valid), .rsp_in_type(rsp_in_type), .rsp_in_mdata(rsp_in_mdata),
      .rsp_valid(rsp_valid), .rsp_rob_idx(rsp_rob_idx), .burst_err(burst_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag);
      tick();
      chk(tag, tx_valid, 1'b0);
   endtask

   task automatic send(input string tag, input logic [41:0] a, input logic [6:0] bc, input logic [8:0] rob,
                       input logic f, input logic i, input logic esop, input logic [1:0] ecl,
                       input logic [41:0] eaddr, input logic [15:0] emd, input logic [1:0] etype);
      logic [31:0] w;
      logic [511:0] d;
      int n;
      w = $urandom();
      d = {16{w}};
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_address = a;
      in_burstcount = bc;
      in_rob_idx = rob;
      in_fence = f;
      in_intr = i;
      in_data = d;
      tick();
      in_valid = 1'b0;
      in_fence = 1'b0;
      in_intr = 1'b0;
      chk({tag, "_valid"}, tx_valid, 1'b1);
      chk({tag, "_sop"}, tx_sop, esop);
      chk({tag, "_cl_len"}, tx_cl_len, ecl);
      chk({tag, "_mdata"}, tx_mdata, emd);
      chk({tag, "_type"}, tx_req_type, etype);
      chk({tag, "_data"}, tx_data, d);
      if (etype == 2'd0)
         chk({tag, "_addr"}, tx_address, eaddr);
   endtask

   task automatic rsp(input string tag, input logic [1:0] t, input logic [15:0] md, input logic [8:0] exp);
      rsp_in_valid = 1'b1;
      rsp_in_type = t;
      rsp_in_mdata = md;
      tick();
      rsp_in_valid = 1'b0;
      chk({tag, "_rv"}, rsp_valid, 1'b1);
      chk({tag, "_rob"}, rsp_rob_idx, exp);
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0;
      in_address = '0;
      in_burstcount = '0;
      in_data = '0;
      in_rob_idx = '0;
      in_fence = 1'b0;
      in_intr = 1'b0;
      tx_almfull = 1'b0;
      rsp_in_valid = 1'b0;
      rsp_in_type = '0;
      rsp_in_mdata = '0;
      repeat (3) tick();
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_rspv", rsp_valid, 1'b0);
      chk("rst_err", burst_err, 1'b0);
      reset_n = 1'b1;
      tick();
      chk("ready_up", in_ready, 1'b1);

      for (int k = 0; k < 8; k++)
         send($sformatf("b8_%0d", k), k == 0 ? 42'h100 : 42'h3ff, 7'd8, k == 0 ? 9'h10 : 9'h0, 1'b0, 1'b0,
              (k % 4) == 0, 2'd3, 42'(256 + k), k < 4 ? 16'h10 : 16'h14, 2'd0);
      idle("b8_idle");

      send("b7_0", 42'h101, 7'd7, 9'h1fe, 1'b0, 1'b0, 1'b1, 2'd0, 42'h101, 16'h1fe, 2'd0);
      send("b7_1", 42'h3ff, 7'd7, 9'h0, 1'b0, 1'b0, 1'b1, 2'd1, 42'h102, 16'h1ff, 2'd0);
      send("b7_2", 42'h3ff, 7'd7, 9'h0, 1'b0, 1'b0, 1'b0, 2'd1, 42'h103, 16'h1ff, 2'd0);
      send("b7_3", 42'h3ff, 7'd7, 9'h0, 1'b0, 1'b0, 1'b1, 2'd3, 42'h104, 16'h001, 2'd0);
      send("b7_4", 42'h3ff, 7'd7, 9'h0, 1'b0, 1'b0, 1'b0, 2'd3, 42'h105, 16'h001, 2'd0);
      send("b7_5", 42'h3ff, 7'd7, 9'h0, 1'b0, 1'b0, 1'b0, 2'd3, 42'h106, 16'h001, 2'd0);
      send("b7_6", 42'h3ff, 7'd7, 9'h0, 1'b0, 1'b0, 1'b0, 2'd3, 42'h107, 16'h001, 2'd0);
      idle("b7_idle");

      send("af_0", 42'h200, 7'd4, 9'h20, 1'b0, 1'b0, 1'b1, 2'd3, 42'h200, 16'h20, 2'd0);
      send("af_1", 42'h3ff, 7'd4, 9'h0, 1'b0, 1'b0, 1'b0, 2'd3, 42'h201, 16'h20, 2'd0);
      tx_almfull = 1'b1;
      send("af_2", 42'h3ff, 7'd4, 9'h0, 1'b0, 1'b0, 1'b0, 2'd3, 42'h202, 16'h20, 2'd0);
      chk("af_ready_low", in_ready, 1'b0);
      in_valid = 1'b1;
      in_address = 42'h3ff;
      in_data = {16{32'hcafe_f00d}};
      tick();
      chk("af_hold0", tx_valid, 1'b0);
      tick();
      chk("af_hold1", tx_valid, 1'b0);
      tx_almfull = 1'b0;
      tick();
      chk("af_ready_back", in_ready, 1'b1);
      chk("af_hold2", tx_valid, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("af_3_valid", tx_valid, 1'b1);
      chk("af_3_sop", tx_sop, 1'b0);
      chk("af_3_addr", tx_address, 42'h203);
      chk("af_3_mdata", tx_mdata, 16'h20);
      chk("af_3_data", tx_data, {16{32'hcafe_f00d}});
      idle("af_idle");

      send("intr", 42'h2, 7'd1, 9'h15, 1'b0, 1'b1, 1'b1, 2'd0, 42'h0, 16'h2, 2'd2);
      chk("intr_err", burst_err, 1'b0);
      rsp("rsp_intr", 2'd2, 16'h2, 9'h15);
      tick();
      chk("rsp_idle", rsp_valid, 1'b0);
      send("fence", 42'h0, 7'd1, 9'h30, 1'b1, 1'b0, 1'b1, 2'd0, 42'h0, 16'h30, 2'd1);
      rsp("rsp_fence", 2'd1, 16'h30, 9'h30);
      rsp("rsp_wr", 2'd0, 16'hf1a5, 9'h1a5);
      rsp_in_valid = 1'b1;
      rsp_in_type = 2'd2;
      rsp_in_mdata = 16'h2;
      send("intr2", 42'h2, 7'd1, 9'h77, 1'b0, 1'b1, 1'b1, 2'd0, 42'h0, 16'h2, 2'd2);
      chk("rsp_old", rsp_rob_idx, 9'h15);
      tick();
      rsp_in_valid = 1'b0;
      chk("rsp_new", rsp_rob_idx, 9'h77);

      send("rb_0", 42'h100, 7'd8, 9'h10, 1'b0, 1'b0, 1'b1, 2'd3, 42'h100, 16'h10, 2'd0);
      send("rb_1", 42'h3ff, 7'd8, 9'h0, 1'b0, 1'b0, 1'b0, 2'd3, 42'h101, 16'h10, 2'd0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_txv", tx_valid, 1'b0);
      chk("rst_mid_ready", in_ready, 1'b0);
      tick();
      reset_n = 1'b1;
      send("r3_0", 42'h200, 7'd3, 9'h60, 1'b0, 1'b0, 1'b1, 2'd1, 42'h200, 16'h60, 2'd0);
      send("r3_1", 42'h3ff, 7'd3, 9'h0, 1'b0, 1'b0, 1'b0, 2'd1, 42'h201, 16'h60, 2'd0);
      send("r3_2", 42'h3ff, 7'd3, 9'h0, 1'b0, 1'b0, 1'b1, 2'd0, 42'h202, 16'h62, 2'd0);
      idle("r3_idle");

      send("bc0", 42'h300, 7'd0, 9'h40, 1'b0, 1'b0, 1'b1, 2'd0, 42'h300, 16'h40, 2'd0);
      chk("bc0_err", burst_err, 1'b1);
      send("bc0_next", 42'h301, 7'd1, 9'h41, 1'b0, 1'b0, 1'b1, 2'd0, 42'h301, 16'h41, 2'd0);
      chk("bc0_sticky", burst_err, 1'b1);
      reset_n = 1'b0;
      tick();
      chk("err_cleared", burst_err, 1'b0);
      reset_n = 1'b1;

      send("ib_0", 42'h2, 7'd2, 9'h50, 1'b0, 1'b1, 1'b1, 2'd1, 42'h2, 16'h50, 2'd0);
      chk("ib_err", burst_err, 1'b1);
      send("ib_1", 42'h3ff, 7'd2, 9'h0, 1'b0, 1'b0, 1'b0, 2'd1, 42'h3, 16'h50, 2'd0);
      idle("ib_idle");
      rsp("rsp_tbl_kept", 2'd2, 16'h2, 9'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
